// File: rtl/dm_load_responder_if.sv
// MEM-stage <-> data-memory responder bus.
//   master : MEM stage; drives Req/Stall/MemAddr/MemByteEn/MemWD/MemRead/
//            MemLen/MemSign/PC and receives MemRD/RdValid.
//   slave  : dm_load_responder; the mirror image.
interface dm_load_responder_if;
  logic        Req;
  logic        Stall;
  logic [31:0] MemAddr;
  logic [3:0]  MemByteEn;
  logic [31:0] MemWD;
  logic        MemRead;
  logic [7:0]  MemLen;
  logic        MemSign;
  logic [31:0] PC;
  logic [31:0] MemRD;
  logic        RdValid;

  modport master (
    output Req, Stall, MemAddr, MemByteEn, MemWD, MemRead, MemLen, MemSign, PC,
    input  MemRD, RdValid
  );

  modport slave (
    input  Req, Stall, MemAddr, MemByteEn, MemWD, MemRead, MemLen, MemSign, PC,
    output MemRD, RdValid
  );
endinterface

// File: rtl/dm_load_responder.sv
// dm_load_responder: data memory behind the MEM stage.
//   Byte-lane writes into a DEPTH-word array; load data is captured on the
//   edge the load is sampled (write-first against a same-cycle store) and
//   presented one clock later, lane-selected and zero/sign extended.
//   Serves byte addresses 0..ADDR_LIMIT; anything above reads 0 and
//   silently drops writes.
// Ports:
//   clk    system clock, posedge
//   reset  asynchronous, active high; clears result regs and the array
//   bus    dm_load_responder_if.slave (Req, Stall, MemAddr, MemByteEn,
//          MemWD, MemRead, MemLen, MemSign, PC in; MemRD, RdValid out)
// Build option:
//   DM_WRITE_LOG_EN  when defined, prints one line per committed write.
//                    Otherwise PC is ignored.

`ifndef MemLenW
  `define MemLenW 8'd2
`endif
`ifndef MemLenH
  `define MemLenH 8'd1
`endif
`ifndef MemLenB
  `define MemLenB 8'd0
`endif

module dm_load_responder #(
  parameter int          DEPTH      = 3072,
  parameter logic [31:0] ADDR_LIMIT = 32'h2FFF
) (
  input logic               clk,
  input logic               reset,
  dm_load_responder_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int IW        = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic          in_range, we;
  logic [IW-1:0] idx;
  logic [31:0]   cur_word, merged, cap_word;
  logic [NUM_LANES-1:0][VEC_W-1:0] cur_l, wd_l, mrg_l;

  assign in_range = (bus.MemAddr <= ADDR_LIMIT);
  assign idx      = bus.MemAddr[IW+1:2];
  // Gate the array read so an out-of-range index never reaches mem[]
  assign cur_word = in_range ? mem[idx] : '0;
  assign cur_l    = cur_word;
  assign wd_l     = bus.MemWD;

  // Per-lane write merge; MemWD is already replicated across lanes
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign mrg_l[l] = bus.MemByteEn[l] ? wd_l[l] : cur_l[l];
  end
  assign merged = mrg_l;

  assign we = !bus.Req && in_range && (|bus.MemByteEn);
  // Write-first: a load sees the lanes stored on the same edge
  assign cap_word = we ? merged : cur_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= merged;
`ifdef DM_WRITE_LOG_EN
      $display("%d@%h: *%h <= %h", $time, bus.PC, {bus.MemAddr[31:2], 2'b00}, merged);
`endif
    end
  end

`ifndef DM_WRITE_LOG_EN
  logic unused_pc;
  assign unused_pc = ^bus.PC;
`endif

  // Registered load result
  logic        rd_valid, rd_sign;
  logic [31:0] rd_word;
  logic [1:0]  rd_off;
  logic [7:0]  rd_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_word  <= '0;
      rd_off   <= '0;
      rd_len   <= '0;
      rd_sign  <= 1'b0;
    end else if (!bus.Stall) begin
      rd_valid <= bus.MemRead && !bus.Req;
      rd_word  <= cap_word;
      rd_off   <= bus.MemAddr[1:0];
      rd_len   <= bus.MemLen;
      rd_sign  <= bus.MemSign;
    end else if (bus.Req) begin
      // flush beats stall: drop the held result, keep the rest frozen
      rd_valid <= 1'b0;
    end
  end

  // Lane select + extension
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_l;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] ext;

  assign rd_l    = rd_word;
  assign rd_half = rd_off[1] ? rd_word[31:16] : rd_word[15:0];
  assign rd_byte = rd_l[rd_off];

  always_comb begin
    ext = rd_word;
    case (rd_len)
      `MemLenW: ext = rd_word;
      `MemLenH: ext = {{16{rd_sign & rd_half[15]}}, rd_half};
      `MemLenB: ext = {{24{rd_sign & rd_byte[7]}}, rd_byte};
      default:  ext = rd_word;
    endcase
  end

  assign bus.MemRD   = rd_valid ? ext : '0;
  assign bus.RdValid = rd_valid;
endmodule
